// File: rtl/uart_transmitter.sv
// 8N1 UART transmit engine on a 16x oversampled baud clock.
// One byte per accepted request, LSB first, all outputs registered.
module uart_transmitter #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic       BaudRate_clk,
  input  logic       reset,
  input  logic [7:0] TX_DATA,
  input  logic       TX_EN,
  output logic       UART_TX,
  output logic       TX_STATUS,
  output logic       TX_DONE
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  localparam logic [3:0] TickLast = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BitLast  = 3'(DATA_BITS - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       tx_q, tx_d;
  logic       status_q, status_d;
  logic       done_q, done_d;

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    status_d = status_q;
    done_d   = 1'b0;

    case (state_q)
      StIdle: begin
        tx_d     = 1'b1;
        status_d = 1'b1;
        if (TX_EN) begin
          shift_d  = TX_DATA;
          tick_d   = 4'd0;
          bit_d    = 3'd0;
          state_d  = StStart;
          tx_d     = 1'b0;
          status_d = 1'b0;
        end
      end
      StStart: begin
        tick_d = tick_q + 4'd1;
        if (tick_q == TickLast) begin
          state_d = StData;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        tick_d = tick_q + 4'd1;
        if (tick_q == TickLast) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == BitLast) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            // Next bit is what lands in shift[0] after this shift.
            tx_d = shift_q[1];
          end
        end
      end
      StStop: begin
        tick_d = tick_q + 4'd1;
        tx_d   = 1'b1;
        if (tick_q == TickLast) begin
          state_d  = StIdle;
          status_d = 1'b1;
          done_d   = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge BaudRate_clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      tick_q   <= 4'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
      status_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      status_q <= status_d;
      done_q   <= done_d;
    end
  end

  assign UART_TX   = tx_q;
  assign TX_STATUS = status_q;
  assign TX_DONE   = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: expected bytes are queued at request time
// and checked against the serial waveform cycle by cycle.
module tb_uart_transmitter;

  logic       BaudRate_clk;
  logic       reset;
  logic [7:0] TX_DATA;
  logic       TX_EN;
  logic       UART_TX;
  logic       TX_STATUS;
  logic       TX_DONE;

  int compared   = 0;
  int mismatched = 0;
  logic [7:0] sb[$];

  uart_transmitter #(
    .OVERSAMPLE(16),
    .DATA_BITS (8)
  ) dut (
    .BaudRate_clk(BaudRate_clk),
    .reset       (reset),
    .TX_DATA     (TX_DATA),
    .TX_EN       (TX_EN),
    .UART_TX     (UART_TX),
    .TX_STATUS   (TX_STATUS),
    .TX_DONE     (TX_DONE)
  );

  initial begin
    BaudRate_clk = 1'b0;
    forever #5 BaudRate_clk = ~BaudRate_clk;
  end

  task automatic tick();
    @(negedge BaudRate_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    compared++;
    assert (obs === want)
    else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  // Called at the negedge just after the accepting edge (n = 0). Returns at the
  // negedge after E161, which is n = 0 of a following frame if one was accepted.
  task automatic check_frame(input bit busy, input int drop_en_at);
    logic [7:0] b;
    logic [9:0] want;
    logic [9:0] got;
    bit tx_ok, st_ok, dn_ok;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'(sb.size()), 32'd1);
      return;
    end
    b     = sb.pop_front();
    want  = {1'b1, b, 1'b0};
    got   = '0;
    tx_ok = 1'b1;
    st_ok = 1'b1;
    dn_ok = 1'b1;
    for (int n = 0; n < 160; n++) begin
      if (UART_TX !== want[n/16]) tx_ok = 1'b0;
      if (TX_STATUS !== 1'b0) st_ok = 1'b0;
      if (TX_DONE !== 1'b0) dn_ok = 1'b0;
      if (n % 16 == 8) got[n/16] = UART_TX;
      if (busy) begin
        case (n)
          39, 149: begin
            TX_EN   = 1'b1;
            TX_DATA = 8'hFF;
          end
          40, 150: TX_EN = 1'b0;
          80:      TX_DATA = 8'($urandom);
          default: ;
        endcase
      end
      if (n == drop_en_at) TX_EN = 1'b0;
      tick();
    end
    chk("mid_bit_samples", 32'(got), 32'(want));
    chk("line_waveform", 32'(tx_ok), 32'd1);
    chk("status_busy", 32'(st_ok), 32'd1);
    chk("done_low_in_frame", 32'(dn_ok), 32'd1);
    chk("line_e160", 32'(UART_TX), 32'd1);
    chk("status_e160", 32'(TX_STATUS), 32'd1);
    chk("done_e160", 32'(TX_DONE), 32'd1);
    tick();
    chk("done_e161", 32'(TX_DONE), 32'd0);
  endtask

  task automatic send(input logic [7:0] b);
    TX_DATA = b;
    TX_EN   = 1'b1;
    sb.push_back(b);
    tick();
    TX_EN = 1'b0;
  endtask

  initial begin
    bit ok;
    logic [7:0] lb[5];
    lb = '{8'h00, 8'hFF, 8'h55, 8'h80, 8'h01};

    // Reset with random inputs.
    reset   = 1'b0;
    TX_EN   = 1'($urandom);
    TX_DATA = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_line", 32'(UART_TX), 32'd1);
      chk("rst_status", 32'(TX_STATUS), 32'd1);
      chk("rst_done", 32'(TX_DONE), 32'd0);
      TX_EN   = 1'($urandom);
      TX_DATA = 8'($urandom);
    end
    TX_EN = 1'b0;
    reset = 1'b1;
    ok    = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (UART_TX !== 1'b1 || TX_STATUS !== 1'b1 || TX_DONE !== 1'b0) ok = 1'b0;
    end
    chk("idle_after_release", 32'(ok), 32'd1);

    // Single frame.
    send(8'hA5);
    check_frame(1'b0, -1);

    // Busy requests and data changes mid-frame are ignored.
    send(8'h3C);
    check_frame(1'b1, -1);
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (UART_TX !== 1'b1 || TX_STATUS !== 1'b1) ok = 1'b0;
    end
    chk("no_second_frame", 32'(ok), 32'd1);

    // Back-to-back with TX_EN held high.
    TX_DATA = 8'h00;
    TX_EN   = 1'b1;
    sb.push_back(8'h00);
    tick();
    TX_DATA = 8'hFF;
    sb.push_back(8'hFF);
    check_frame(1'b0, -1);
    check_frame(1'b0, 5);
    chk("b2b_idle_after", 32'(TX_STATUS), 32'd1);

    // Reset mid-frame at E70.
    TX_DATA = 8'h00;
    TX_EN   = 1'b1;
    tick();
    TX_EN = 1'b0;
    repeat (69) tick();
    chk("pre_reset_line", 32'(UART_TX), 32'd0);
    tick();
    #2 reset = 1'b0;
    #1;
    chk("async_rst_line", 32'(UART_TX), 32'd1);
    chk("async_rst_status", 32'(TX_STATUS), 32'd1);
    chk("async_rst_done", 32'(TX_DONE), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    ok    = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (TX_DONE !== 1'b0 || TX_STATUS !== 1'b1 || UART_TX !== 1'b1) ok = 1'b0;
    end
    chk("aborted_no_done", 32'(ok), 32'd1);
    send(8'h5A);
    check_frame(1'b0, -1);

    // Byte set from the loopback plan.
    for (int i = 0; i < 5; i++) begin
      send(lb[i]);
      check_frame(1'b0, -1);
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
